// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multicycle RV32I core.
// Drives every register enable (PC, IR/OldPC, register file, data memory)
// and the datapath mux selects. Outputs are Moore-decoded from state except
// pc_write in BEQ (gated by zero) and alu_control (state + funct fields).
// Optional feature macro: ILLEGAL_TRAP_EN -- unknown opcodes enter an
// absorbing TRAP state and an extra 'illegal' output is provided.
module multicycle_controller #(
  parameter int unsigned MEM_LATENCY = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [3:0] state_dbg
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait;
  logic [3:0] w_wait_nxt;
  logic       w_last;
  logic       w_wait_state;
  logic [2:0] w_alu_dec;

  // Memory-facing states hold until the wait counter reaches MEM_LATENCY.
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD);
  assign w_last       = (r_wait == LAT);
  assign w_wait_nxt   = (w_wait_state && !w_last) ? r_wait + 4'd1 : 4'd0;
  assign state_dbg    = r_state;

  // State and wait counter; reset drops straight back to FETCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_BEQ:            w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = w_last ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  // ALU operation for R/I-type execute; sub only for R-type with funct7[5].
  always_comb begin
    w_alu_dec = 3'b000;
    case (funct3)
      3'b000:  w_alu_dec = ((r_state == S_EXECUTER) && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  w_alu_dec = 3'b101;
      3'b110:  w_alu_dec = 3'b011;
      3'b111:  w_alu_dec = 3'b010;
      default: w_alu_dec = 3'b000;
    endcase
  end

  // Per-state output decode; anything not driven by a state stays 0.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_write   = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = w_last;
        ir_write   = w_last;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = w_alu_dec;
      end
      S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = w_alu_dec;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write    = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: two instances (MEM_LATENCY 0
// and 2). Each issued instruction pushes its full expected per-cycle output
// trace; per-instance monitors pop and compare every falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] res, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw, ill;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst [2];
  logic [6:0] op  [2];
  logic [2:0] f3  [2];
  logic       f7  [2];
  logic       zr  [2];
  logic       pcw [2], adr [2], mw [2], irw [2], rw [2];
  logic [1:0] res [2], sa [2], sb [2], imm [2];
  logic [2:0] alu [2];
  logic [3:0] st  [2];
  logic       ill [2];

  int   lat [2] = '{0, 2};
  exp_t q [2][$];
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  multicycle_controller #(.MEM_LATENCY(0)) dut0 (
    .clock(clock), .reset(rst[0]), .op(op[0]), .funct3(f3[0]), .funct7b5(f7[0]),
    .zero(zr[0]), .pc_write(pcw[0]), .adr_src(adr[0]), .mem_write(mw[0]),
    .ir_write(irw[0]), .result_src(res[0]), .alu_src_a(sa[0]), .alu_src_b(sb[0]),
    .alu_control(alu[0]), .imm_src(imm[0]), .reg_write(rw[0]), .state_dbg(st[0])
`ifdef ILLEGAL_TRAP_EN
    , .illegal(ill[0])
`endif
  );

  multicycle_controller #(.MEM_LATENCY(2)) dut1 (
    .clock(clock), .reset(rst[1]), .op(op[1]), .funct3(f3[1]), .funct7b5(f7[1]),
    .zero(zr[1]), .pc_write(pcw[1]), .adr_src(adr[1]), .mem_write(mw[1]),
    .ir_write(irw[1]), .result_src(res[1]), .alu_src_a(sa[1]), .alu_src_b(sb[1]),
    .alu_control(alu[1]), .imm_src(imm[1]), .reg_write(rw[1]), .state_dbg(st[1])
`ifdef ILLEGAL_TRAP_EN
    , .illegal(ill[1])
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign ill[0] = 1'b0;
  assign ill[1] = 1'b0;
`endif

  function automatic logic [2:0] alu_ref(logic [2:0] fn3, logic fn7, bit rtype);
    case (fn3)
      3'b000:  return (rtype && fn7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected outputs for one cycle spent in state s of an instruction.
  function automatic exp_t model(int s, bit last, logic [6:0] o, logic [2:0] fn3,
                                 logic fn7, logic z);
    exp_t e = '0;
    e.st  = 4'(s);
    e.imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 :
            (o == 7'b1101111) ? 2'd3 : 2'd0;
    case (s)
      0:  begin e.sb = 2; e.res = 2; e.pcw = last; e.irw = last; end
      1:  begin e.sa = 1; e.sb = 1; end
      2:  begin e.sa = 2; e.sb = 1; end
      3:  e.adr = 1;
      4:  begin e.res = 1; e.rw = 1; end
      5:  begin e.adr = 1; e.mw = 1; end
      6:  begin e.sa = 2; e.alu = alu_ref(fn3, fn7, 1); end
      7:  begin e.sa = 2; e.sb = 1; e.alu = alu_ref(fn3, fn7, 0); end
      8:  e.rw = 1;
      9:  begin e.sa = 2; e.alu = 1; e.pcw = z; end
      10: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      11: e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t actual(int k);
    return {st[k], pcw[k], adr[k], mw[k], irw[k], res[k], sa[k], sb[k],
            alu[k], imm[k], rw[k], ill[k]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one instruction on instance k starting at the first FETCH cycle
  // (called just after a rising edge); push its trace, then let it run.
  task automatic issue(int k, logic [6:0] o, logic [2:0] fn3, logic fn7, logic z);
    int n0 = q[k].size();
    op[k] = o; f3[k] = fn3; f7[k] = fn7; zr[k] = z;
    for (int i = 0; i <= lat[k]; i++) q[k].push_back(model(0, i == lat[k], o, fn3, fn7, z));
    q[k].push_back(model(1, 0, o, fn3, fn7, z));
    case (o)
      7'b0000011: begin
        q[k].push_back(model(2, 0, o, fn3, fn7, z));
        for (int i = 0; i <= lat[k]; i++) q[k].push_back(model(3, 0, o, fn3, fn7, z));
        q[k].push_back(model(4, 0, o, fn3, fn7, z));
      end
      7'b0100011: begin
        q[k].push_back(model(2, 0, o, fn3, fn7, z));
        q[k].push_back(model(5, 0, o, fn3, fn7, z));
      end
      7'b0110011: begin
        q[k].push_back(model(6, 0, o, fn3, fn7, z));
        q[k].push_back(model(8, 0, o, fn3, fn7, z));
      end
      7'b0010011: begin
        q[k].push_back(model(7, 0, o, fn3, fn7, z));
        q[k].push_back(model(8, 0, o, fn3, fn7, z));
      end
      7'b1100011: q[k].push_back(model(9, 0, o, fn3, fn7, z));
      7'b1101111: begin
        q[k].push_back(model(10, 0, o, fn3, fn7, z));
        q[k].push_back(model(8, 0, o, fn3, fn7, z));
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) q[k].push_back(model(11, 0, o, fn3, fn7, z));
`endif
      end
    endcase
    repeat (q[k].size() - n0) @(posedge clock);
    #1;
`ifdef ILLEGAL_TRAP_EN
    if (!(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                    7'b1100011, 7'b1101111})) begin
      rst[k] = 1'b1;
      @(posedge clock); #1;
      rst[k] = 1'b0;
    end
`endif
  endtask

  task automatic monitor(int k);
    exp_t e, a;
    forever begin
      @(negedge clock);
      if (q[k].size() > 0) begin
        e = q[k].pop_front();
        a = actual(k);
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL dut%0d trace st=%0d: got %h expected %h", k, e.st, a, e);
        end
      end
    end
  endtask

  task automatic run_random(int k, int n);
    logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                            7'b0010011, 7'b1100011, 7'b1101111};
    logic [6:0] o;
    for (int i = 0; i < n; i++) begin
      int sel = $urandom_range(0, 6);
      if (sel == 6) begin
`ifdef ILLEGAL_TRAP_EN
        o = ops[$urandom_range(0, 5)];
`else
        o = 7'($urandom);
        if (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b1100011, 7'b1101111}) o = 7'b0000000;
`endif
      end else o = ops[sel];
      issue(k, o, 3'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic stim(int k);
    exp_t r;
    rst[k] = 1'b1; op[k] = '0; f3[k] = '0; f7[k] = 0; zr[k] = 0;
    repeat (2) @(posedge clock);
    #1;
    rst[k] = 1'b0;
    if (k == 0) begin
      // sw up to MEMWRITE, then reset mid-store
      op[k] = 7'b0100011;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("memwrite_state", 32'(st[k]), 32'd5);
      check("memwrite_strobe", 32'(mw[k]), 32'd1);
      rst[k] = 1'b1;
      #1;
      check("reset_state_same_cycle", 32'(st[k]), 32'd0);
      check("reset_mem_write_drop", 32'(mw[k]), 32'd0);
      r = model(0, 1, 7'b0100011, 3'd0, 1'b0, 1'b0);
      check("reset_outputs", 32'(actual(k)), 32'(r));
      @(posedge clock); #1;
      rst[k] = 1'b0;
      check("post_reset_pc_write", 32'(pcw[k]), 32'd1);
      check("post_reset_ir_write", 32'(irw[k]), 32'd1);
    end
    // directed cases, traced by the scoreboard
    issue(k, 7'b0000011, 3'd2, 1'b0, 1'b0);   // lw
    issue(k, 7'b0110011, 3'd0, 1'b0, 1'b0);   // add
    issue(k, 7'b0110011, 3'd0, 1'b1, 1'b0);   // sub
    issue(k, 7'b0010011, 3'd0, 1'b1, 1'b0);   // addi with funct7b5 set
    issue(k, 7'b1100011, 3'd0, 1'b0, 1'b1);   // beq taken
    issue(k, 7'b1100011, 3'd0, 1'b0, 1'b0);   // beq not taken
    issue(k, 7'b1101111, 3'd0, 1'b0, 1'b0);   // jal
    issue(k, 7'b0100011, 3'd2, 1'b0, 1'b0);   // sw
    run_random(k, 60);
    issue(k, 7'b0000000, 3'd0, 1'b0, 1'b0);   // illegal opcode
    issue(k, 7'b0010011, 3'd7, 1'b0, 1'b0);   // andi after it
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
    fork
      stim(0);
      stim(1);
    join
    for (int i = 0; i < 50 && (q[0].size() > 0 || q[1].size() > 0); i++)
      @(posedge clock);
    tests++;
    if (q[0].size() > 0 || q[1].size() > 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q[0].size(), q[1].size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32I core. It generates the enable strobes (pc_write, ir_write, reg_write, mem_write) and the datapath mux selects that drive the core's enabled/reset flip-flop registers (PC, IR, OldPC, Data, ALUOut). It sits between the instruction register outputs (op/funct fields), the ALU zero flag and the datapath, and is the initiator of every register-enable in the core.

Parameters:
MEM_LATENCY, 0, extra wait cycles held in FETCH and MEMREAD before advancing (0..15); internal wait counter 4 bits.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces FETCH
op  input  7  instruction opcode (IR[6:0])
funct3  input  3  IR[14:12]
funct7b5  input  1  IR[30]
zero  input  1  ALU zero flag (combinational, current cycle)
pc_write  output  1  PC register enable
adr_src  output  1  memory address select: 0 PC, 1 ALUOut
mem_write  output  1  data memory write strobe
ir_write  output  1  IR + OldPC register enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 rd1
alu_src_b  output  2  00 rd2, 01 imm, 10 constant 4
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  output  2  00 I, 01 S, 10 B, 11 J
reg_write  output  1  register file write enable
state_dbg  output  4  current state encoding (debug)

Behaviour:
- State register updates on posedge clock; reset (async, active-high) forces FETCH and clears wait counter. All outputs are decoded from state (Moore), except pc_write in BEQ (state AND zero) and alu_control (state + funct fields).
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.
- FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, alu add, result_src 10, pc_write 1 on the final wait cycle only; ir_write likewise asserted only on final cycle. Holds MEM_LATENCY extra cycles, then -> DECODE.
- DECODE: alu_src_a 01, alu_src_b 01, add (branch target into ALUOut). Next: op 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; otherwise -> FETCH (TRAP if macro enabled).
- MEMADR: alu_src_a 10, alu_src_b 01, add; next MEMREAD if op=0000011 else MEMWRITE.
- MEMREAD: adr_src 1, result_src 00; holds MEM_LATENCY extra cycles -> MEMWB.
- MEMWB: result_src 01, reg_write 1 -> FETCH.
- MEMWRITE: adr_src 1, result_src 00, mem_write 1 (exactly one cycle) -> FETCH.
- EXECUTER/EXECUTEI: alu_src_a 10, alu_src_b 00/01, ALU decode -> ALUWB.
- ALUWB: result_src 00, reg_write 1 -> FETCH.
- BEQ: alu_src_a 10, alu_src_b 00, sub, result_src 00, pc_write = zero -> FETCH.
- JAL: alu_src_a 01, alu_src_b 10, add, result_src 00, pc_write 1 -> ALUWB.
- ALU decode (EXECUTER/EXECUTEI): funct3 000 -> sub if EXECUTER and funct7b5=1, else add; 010 slt; 110 or; 111 and; others add.
- imm_src from op: 0100011 S, 1100011 B, 1101111 J, else I.
- Every output not listed for a state is 0. Reset value of all outputs: FETCH decode (ir_write/pc_write 1 only if MEM_LATENCY=0).
- Reset mid-instruction: pending mem_write/reg_write deasserts immediately (async).

Optional Feature:
ILLEGAL_TRAP_EN: defined -> unknown opcode in DECODE enters TRAP; TRAP asserts no enables and is absorbing until reset; extra output illegal (1 bit) high in TRAP. Undefined -> unknown opcode returns to FETCH (NOP), no illegal port.

Test Plan:
- Reset asserted mid-MEMWRITE -> state_dbg=0 same cycle, mem_write=0; release -> FETCH with pc_write=1, ir_write=1 (MEM_LATENCY=0).
- lw op=0000011 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB, result_src=01.
- add vs sub: op=0110011, funct3=000, funct7b5=0/1 -> alu_control 000/001 in EXECUTER; addi with funct7b5=1 -> 000.
- beq op=1100011 with zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; 3 cycles total either way.
- jal op=1101111 -> 0,1,10,8,0; pc_write=1 in JAL, reg_write=1 in ALUWB, imm_src=11.
- MEM_LATENCY=2, sw -> FETCH lasts 3 cycles with ir_write only on third; op=0000000 -> TRAP with illegal=1 (macro on) or FETCH (macro off).
